// File: rtl/path_sender.sv
// path_sender
// Walks the predecessor RAM from destino back to fonte and pushes each node onto a
// LIFO. It then streams the path out fonte..destino over a valid/ready handshake.
// A missing parent, or a chain longer than MAX_PATH nodes, aborts with an error pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle request, honoured only in IDLE
//   fonte, destino      source / destination node, latched on start
//   pred_rd_en/addr     predecessor RAM read strobe and address
//   pred_data           RAM read data, valid the cycle after pred_rd_en
//   out_valid/ready     output handshake; out_node is the beat, out_last marks destino
//   busy                high outside IDLE
//   done / error        1-cycle completion / abort pulses
//
// state  | meaning
// IDLE   | waiting for start
// PUSH   | push cur onto LIFO, issue RAM read unless cur is fonte
// RD     | RAM latency cycle
// CHK    | validate parent, advance cur or abort
// SEND   | stream LIFO top-first (fonte first)
// FIN    | done pulse
// ERR    | error pulse, LIFO discarded
module path_sender #(
  parameter int NODE_WIDTH = 8,
  parameter int MAX_PATH   = 256,
  parameter logic [NODE_WIDTH-1:0] NO_PARENT = {NODE_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NODE_WIDTH-1:0] fonte,
  input  logic [NODE_WIDTH-1:0] destino,
  output logic                  pred_rd_en,
  output logic [NODE_WIDTH-1:0] pred_addr,
  input  logic [NODE_WIDTH-1:0] pred_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NODE_WIDTH-1:0] out_node,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int AW = $clog2(MAX_PATH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_RD, S_CHK, S_SEND, S_FIN, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NODE_WIDTH-1:0]   cur_q, cur_d;
  logic [NODE_WIDTH-1:0]   fonte_q, fonte_d;
  logic                    vld_q, vld_d;
  logic [NODE_WIDTH-1:0]   node_q, node_d;
  logic                    last_q, last_d;

  logic [NODE_WIDTH-1:0]   lifo_q [MAX_PATH];
  logic [AW-1:0]           wr_idx, top_idx, nxt_idx;

  assign wr_idx  = AW'(ptr_q);
  assign top_idx = AW'(ptr_q - PW'(1));
  assign nxt_idx = AW'(ptr_q - PW'(2));

  // Storage only; validity is tracked by ptr_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (state_q == S_PUSH) lifo_q[wr_idx] <= cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      fonte_q <= '0;
      vld_q   <= 1'b0;
      node_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      fonte_q <= fonte_d;
      vld_q   <= vld_d;
      node_q  <= node_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    fonte_d    = fonte_q;
    vld_d      = vld_q;
    node_d     = node_q;
    last_d     = last_q;
    pred_rd_en = 1'b0;
    pred_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fonte_d = fonte;
          cur_d   = destino;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        ptr_d = ptr_q + PW'(1);
        if (cur_q == fonte_q) begin
          state_d = S_SEND;
        end else begin
          pred_rd_en = 1'b1;
          pred_addr  = cur_q;
          state_d    = S_RD;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        // ptr full means one more push would overflow the LIFO
        if (pred_data == NO_PARENT || ptr_q == PW'(MAX_PATH)) begin
          state_d = S_ERR;
        end else begin
          cur_d   = pred_data;
          state_d = S_PUSH;
        end
      end
      S_SEND: begin
        // First SEND cycle loads the output register from the LIFO top; after
        // that each accepted beat preloads the next entry so a continuously
        // ready sink sees one beat per cycle.
        if (!vld_q) begin
          vld_d  = 1'b1;
          node_d = lifo_q[top_idx];
          last_d = (ptr_q == PW'(1));
        end else if (out_ready) begin
          ptr_d = ptr_q - PW'(1);
          if (last_q) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            node_d  = '0;
            state_d = S_FIN;
          end else begin
            node_d = lifo_q[nxt_idx];
            last_d = (ptr_q == PW'(2));
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      S_ERR: begin
        ptr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = vld_q;
  assign out_node  = node_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_path_sender.sv
module tb_path_sender;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, start5 = 1'b0;
  logic [7:0] fonte = '0, destino = '0, fonte5 = '0, destino5 = '0;
  logic       pred_rd_en, pred_rd_en5;
  logic [7:0] pred_addr, pred_addr5;
  logic [7:0] pred_data = '0, pred_data5 = '0;
  logic       out_valid, out_valid5, out_last, out_last5;
  logic       out_ready = 1'b0, out_ready5 = 1'b1;
  logic [7:0] out_node, out_node5;
  logic       busy, busy5, done, done5, error, error5;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] rd_log [$];

  path_sender dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fonte(fonte), .destino(destino),
    .pred_rd_en(pred_rd_en), .pred_addr(pred_addr), .pred_data(pred_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  path_sender #(.MAX_PATH(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .fonte(fonte5), .destino(destino5),
    .pred_rd_en(pred_rd_en5), .pred_addr(pred_addr5), .pred_data(pred_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_node(out_node5),
    .out_last(out_last5), .busy(busy5), .done(done5), .error(error5)
  );

  always @(posedge clk) begin
    if (pred_rd_en)  pred_data  <= mem[pred_addr];
    if (pred_rd_en5) pred_data5 <= mem[pred_addr5];
  end

  always @(negedge clk) begin
    if (pred_rd_en) rd_log.push_back(pred_addr);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    rd_log.delete();
    exp_q.delete();
  endtask

  task automatic do_start(input logic [7:0] f, input logic [7:0] d);
    @(negedge clk);
    fonte = f; destino = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard consumer: drives out_ready by pattern, pops expected beats.
  task automatic collect(input int rmod, input int first_cyc, input int budget, input string tag);
    int cyc; bit held, seen, want_done, fin;
    logic [7:0] hn, e; logic hl, exp_last;
    cyc = 0; held = 0; seen = 0; want_done = 0; fin = 0; hn = '0; hl = 0;
    while (!fin && cyc < budget) begin
      out_ready = ((cyc % rmod) == 0);
      if (want_done) begin
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL %s done_pulse: got %0b expected 1", tag, done); end
        fin = 1;
      end else begin
        if (held) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_node !== hn || out_last !== hl) begin
            n_err++;
            $display("FAIL %s hold_stable: got v=%0b n=%0d l=%0b expected v=1 n=%0d l=%0b",
                     tag, out_valid, out_node, out_last, hn, hl);
          end
        end
        if (out_valid === 1'b1 && !seen) begin
          seen = 1;
          if (first_cyc >= 0) begin
            n_cmp++;
            if (cyc != first_cyc) begin n_err++; $display("FAIL %s first_valid_cycle: got %0d expected %0d", tag, cyc, first_cyc); end
          end
        end
        if (out_valid === 1'b1 && out_ready) begin
          held = 0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL %s extra_beat: got node %0d expected none", tag, out_node);
          end else begin
            e = exp_q.pop_front();
            exp_last = (exp_q.size() == 0);
            if (out_node !== e || out_last !== exp_last) begin
              n_err++;
              $display("FAIL %s beat: got n=%0d l=%0b expected n=%0d l=%0b", tag, out_node, out_last, e, exp_last);
            end
          end
          if (out_last === 1'b1) want_done = 1;
        end else if (out_valid === 1'b1) begin
          held = 1; hn = out_node; hl = out_last;
        end else begin
          held = 0;
        end
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!fin || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s completion: got fin=%0b left=%0d expected fin=1 left=0", tag, fin, exp_q.size());
    end
  endtask

  task automatic wait_error(input bit use5, input int exp_cyc, input int budget, input string tag);
    int cyc, beats; bit got;
    logic v, er, b;
    cyc = 0; beats = 0; got = 0;
    out_ready = 1'b1;
    while (!got && cyc < budget) begin
      v  = use5 ? out_valid5 : out_valid;
      er = use5 ? error5 : error;
      if (v === 1'b1) beats++;
      if (er === 1'b1) begin
        got = 1;
        n_cmp++;
        if (cyc != exp_cyc) begin n_err++; $display("FAIL %s error_cycle: got %0d expected %0d", tag, cyc, exp_cyc); end
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL %s error_seen: got 0 expected 1 (timeout)", tag); end
    n_cmp++;
    if (beats != 0) begin n_err++; $display("FAIL %s no_beats: got %0d expected 0", tag, beats); end
    b = use5 ? busy5 : busy;
    n_cmp++;
    if (b !== 1'b0) begin n_err++; $display("FAIL %s busy_after_error: got %0b expected 0", tag, b); end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({pred_rd_en, pred_addr, out_valid, out_node, out_last, busy, done, error} !== '0) begin
      n_err++;
      $display("FAIL %s outputs_zero: got rd=%0b a=%0d v=%0b n=%0d l=%0b b=%0b d=%0b e=%0b expected all 0",
               tag, pred_rd_en, pred_addr, out_valid, out_node, out_last, busy, done, error);
    end
    n_cmp++;
    if ({out_valid5, busy5, error5, done5} !== '0) begin
      n_err++; $display("FAIL %s outputs5_zero: got v=%0b b=%0b e=%0b d=%0b expected 0", tag, out_valid5, busy5, error5, done5);
    end
  endtask

  task automatic setup_t2();
    clear_all();
    mem[9] = 8'd5; mem[5] = 8'd2; mem[2] = 8'd0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd5); exp_q.push_back(8'd9);
  endtask

  task automatic check_reads_t2(input string tag);
    logic [7:0] exp_rd [3];
    exp_rd[0] = 8'd9; exp_rd[1] = 8'd5; exp_rd[2] = 8'd2;
    n_cmp++;
    if (rd_log.size() != 3) begin
      n_err++; $display("FAIL %s read_count: got %0d expected 3", tag, rd_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rd_log[i] !== exp_rd[i]) begin n_err++; $display("FAIL %s read_addr%0d: got %0d expected %0d", tag, i, rd_log[i], exp_rd[i]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_single();
    clear_all();
    exp_q.push_back(8'd3);
    do_start(8'd3, 8'd3);
    collect(1, 2, 20, "t1_single");
    n_cmp++;
    if (rd_log.size() != 0) begin n_err++; $display("FAIL t1_single no_reads: got %0d expected 0", rd_log.size()); end
  endtask

  task automatic test_chain();
    setup_t2();
    do_start(8'd0, 8'd9);
    collect(1, 3 * (4 - 1) + 2, 60, "t2_chain");
    check_reads_t2("t2_chain");
  endtask

  task automatic test_backpressure();
    setup_t2();
    do_start(8'd0, 8'd9);
    collect(3, 11, 80, "t3_bp");
  endtask

  task automatic test_broken();
    clear_all();
    mem[9] = 8'd5; mem[5] = 8'hFF;
    do_start(8'd0, 8'd9);
    wait_error(1'b0, 6, 40, "t4_broken");
  endtask

  task automatic test_overflow();
    clear_all();
    mem[7] = 8'd6; mem[6] = 8'd5; mem[5] = 8'd4; mem[4] = 8'd3;
    @(negedge clk);
    fonte5 = 8'd3; destino5 = 8'd7; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    wait_error(1'b1, 12, 60, "t5_overflow");
  endtask

  task automatic test_reset_mid();
    int cyc;
    setup_t2();
    do_start(8'd0, 8'd9);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin cyc++; @(negedge clk); end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL t6 reach_send: got %0b expected 1", out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL t6 quiet_after_reset: got v=%0b b=%0b expected 0 0", out_valid, busy);
      end
    end
    setup_t2();
    do_start(8'd0, 8'd9);
    fonte = 8'd3; destino = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(1, -1, 60, "t6_restart");
    check_reads_t2("t6_restart");
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_backpressure();
    test_broken();
    test_overflow();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
